// File: rtl/serial_tx_d_pkg.sv
// Shared definitions for the serial D-line transmitter: FSM state encodings
// and the line levels used for the frame delimiters.
package serial_tx_d_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_d_bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1, tc marks the last cycle of a bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  output logic tc
);

  localparam int              TW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0]   LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]   ONE  = TW'(1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_d.sv
// Parallel-to-serial transmitter: start bit 0, DATA_W data bits LSB-first,
// stop bit 1, each held CLKS_PER_BIT cycles on a registered TxD line.
module serial_tx_d
  import serial_tx_d_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] D,
  input  logic              Start,
  output logic              Ready,
  output logic              TxD,
  output logic              Done
);

  localparam int            IW       = $clog2(DATA_W) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                txd_q, txd_d;
  logic                done_q, done_d;
  logic                tc;

  // Timer is held at zero while idle so every frame starts on a fresh bit period.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (state_q == S_IDLE),
    .tc    (tc)
  );

  assign Ready = (state_q == S_IDLE);
  assign TxD   = txd_q;
  assign Done  = done_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      txd_q   <= STOP_BIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_START;
          shreg_d = D;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tc) begin
          state_d = S_DATA;
          idx_d   = '0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tc) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (tc) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is computed from the next state so TxD changes together with state_q.
  always_comb begin
    txd_d  = STOP_BIT;
    done_d = (state_q == S_STOP) && tc;
    case (state_d)
      S_START: txd_d = START_BIT;
      S_DATA:  txd_d = shreg_d[0];
      default: txd_d = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_d.sv
// Randomized self-checking bench for serial_tx_d (8 bits x 4 clk/bit and 4 bits x 1 clk/bit).
module tb_serial_tx_d;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] D;
  logic       Start;
  logic       Ready, TxD, Done;
  logic [3:0] D1;
  logic       Start1;
  logic       Ready1, TxD1, Done1;

  int checks = 0;
  int errors = 0;

  serial_tx_d #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .Clk(Clk), .Reset(Reset), .D(D), .Start(Start),
    .Ready(Ready), .TxD(TxD), .Done(Done)
  );

  serial_tx_d #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .D(D1), .Start(Start1),
    .Ready(Ready1), .TxD(TxD1), .Done(Done1)
  );

  always #5 Clk = ~Clk;

  // Reference line level for 0-based cycle cyc of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int w, input int cpb, input int cyc);
    int p;
    p = cyc / cpb;
    if (p == 0) return 1'b0;
    if (p <= w) return d[p-1];
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Start1 = 1'b0; D = 8'h00; D1 = 4'h0;
    step(); step();
    checks++;
    if ({TxD, Ready, Done} !== 3'b110) begin
      errors++;
      $display("FAIL reset_state: TxD/Ready/Done=%b expected 110", {TxD, Ready, Done});
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if ({TxD, Ready, Done, TxD1, Ready1, Done1} !== 6'b110110) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL idle cycle %0d: got %b expected 110110", i,
                              {TxD, Ready, Done, TxD1, Ready1, Done1});
      end
      step();
    end
  endtask

  // One frame of d; optional noise on Start/D during the frame, optional held Start.
  task automatic test_frame(input logic [7:0] d, input bit noise, input bit hold,
                            input logic [7:0] d_next, input string name);
    int bad = 0;
    Start = 1'b1; D = d;
    step();
    if (!hold) Start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (noise) begin
        Start = 1'($urandom_range(0, 1));
        D = 8'($urandom);
      end
      if (hold && i == 20) D = d_next;
      checks++;
      if ({TxD, Ready, Done} !== {exp_bit(d, 8, 4, i), 2'b00}) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL %s cycle %0d: TxD/Ready/Done=%b expected %b", name, i,
                              {TxD, Ready, Done}, {exp_bit(d, 8, 4, i), 2'b00});
      end
      step();
    end
    if (noise) Start = 1'b0;
    checks++;
    if ({TxD, Ready, Done} !== 3'b111) begin
      errors++;
      $display("FAIL %s done_cycle: TxD/Ready/Done=%b expected 111", name, {TxD, Ready, Done});
    end
  endtask

  task automatic test_basic();
    test_frame(8'hA5, 1'b0, 1'b0, 8'h00, "frame_a5");
    step();
    checks++;
    if ({TxD, Ready, Done} !== 3'b110) begin
      errors++;
      $display("FAIL a5_after_done: got %b expected 110", {TxD, Ready, Done});
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      test_frame(d, 1'b0, 1'b0, 8'h00, "random_frame");
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
    end
  endtask

  task automatic test_back_to_back();
    test_frame(8'h01, 1'b0, 1'b1, 8'hFF, "b2b_first");
    // Start still high during the Done cycle: next frame carries the D seen at accept.
    test_frame(8'hFF, 1'b0, 1'b0, 8'h00, "b2b_second");
    step();
  endtask

  task automatic test_ignored_start();
    int bad = 0;
    test_frame(8'h3C, 1'b1, 1'b0, 8'h00, "frame_3c_noise");
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({TxD, Ready, Done} !== 3'b110) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL 3c_single_done cycle %0d: got %b expected 110", i,
                              {TxD, Ready, Done});
      end
    end
  endtask

  task automatic test_mid_reset();
    Start = 1'b1; D = 8'($urandom);
    step();
    Start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({TxD, Ready, Done} !== 3'b110) begin
      errors++;
      $display("FAIL mid_reset_async: got %b expected 110", {TxD, Ready, Done});
    end
    step();
    #2 Reset = 1'b0;
    step();
    checks++;
    if ({TxD, Ready, Done} !== 3'b110) begin
      errors++;
      $display("FAIL after_reset_idle: got %b expected 110", {TxD, Ready, Done});
    end
    test_frame(8'h5A, 1'b0, 1'b0, 8'h00, "frame_5a_after_reset");
    step();
  endtask

  task automatic test_cpb1();
    logic [7:0] d;
    int bad = 0;
    for (int n = 0; n < 4; n++) begin
      d = (n == 0) ? 8'h09 : {4'h0, 4'($urandom)};
      Start1 = 1'b1; D1 = d[3:0];
      step();
      Start1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
        checks++;
        if ({TxD1, Ready1, Done1} !== {exp_bit(d, 4, 1, i), 2'b00}) begin
          errors++; bad++;
          if (bad < 4) $display("FAIL cpb1 frame %0d cycle %0d: got %b expected %b", n, i,
                                {TxD1, Ready1, Done1}, {exp_bit(d, 4, 1, i), 2'b00});
        end
        step();
      end
      checks++;
      if ({TxD1, Ready1, Done1} !== 3'b111) begin
        errors++;
        $display("FAIL cpb1_done frame %0d: got %b expected 111", n, {TxD1, Ready1, Done1});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_random();
    test_back_to_back();
    test_ignored_start();
    test_mid_reset();
    test_cpb1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
